// File: rtl/adbg_pkg.sv
// Shared debug-top constants and the status word layout.
// No logic; no latency; no backpressure.
package adbg_pkg;

  localparam int DBG_TOP_STATUS_LEN = 16;
  localparam logic [3:0] DBG_TOP_STATUS_VERSION = 4'h1;

  typedef struct packed {
    logic [3:0] version;
    logic [7:0] nb_modules;
    logic       err;
    logic [2:0] rsvd;
  } dbg_top_status_t;

endpackage

// File: rtl/adbg_top_sel_if.sv
// TAP-side DR controls, shared shift register and per-module select/TDO bundle.
// No logic; no latency; no backpressure (JTAG has no flow control).
interface adbg_top_sel_if #(
  parameter int NB_MODULES  = 4,
  parameter int DATAREG_LEN = 64
);
  logic                   tdi_i;
  logic                   tdo_o;
  logic                   shift_dr_i;
  logic                   update_dr_i;
  logic                   capture_dr_i;
  logic                   debug_select_i;
  logic [DATAREG_LEN-1:0] data_register_o;
  logic [NB_MODULES-1:0]  module_select_o;
  logic [NB_MODULES-1:0]  module_tdo_i;
  logic [NB_MODULES-1:0]  top_inhibit_i;
  logic                   select_err_o;

  modport master (
    output tdi_i, shift_dr_i, update_dr_i, capture_dr_i, debug_select_i,
           module_tdo_i, top_inhibit_i,
    input  tdo_o, data_register_o, module_select_o, select_err_o
  );

  modport slave (
    input  tdi_i, shift_dr_i, update_dr_i, capture_dr_i, debug_select_i,
           module_tdo_i, top_inhibit_i,
    output tdo_o, data_register_o, module_select_o, select_err_o
  );
endinterface

// File: rtl/adbg_top_status.sv
// Status word capture/shift register (built only with ADBG_TOP_STATUS_EN).
// Loads on capture, shifts LSB-first one bit per TCK; no backpressure.
module adbg_top_status
  import adbg_pkg::*;
#(
  parameter int         NB_MODULES     = 4,
  parameter logic [3:0] STATUS_VERSION = DBG_TOP_STATUS_VERSION
) (
  input  logic tck_i,
  input  logic rst_i,
  input  logic capture_i,
  input  logic shift_i,
  input  logic err_i,
  output logic status_tdo_o
);

  dbg_top_status_t                status_word;
  logic [DBG_TOP_STATUS_LEN-1:0]  status_d, status_q;

  always_comb begin
    status_word.version    = STATUS_VERSION;
    status_word.nb_modules = NB_MODULES[7:0];
    status_word.err        = err_i;
    status_word.rsvd       = '0;

    status_d = status_q;
    if (capture_i) begin
      status_d = status_word;
    end else if (shift_i) begin
      status_d = {1'b0, status_q[DBG_TOP_STATUS_LEN-1:1]};
    end
  end

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_tdo_o = status_q[0];

endmodule

// File: rtl/adbg_top_sel.sv
// Debug module select and TDO routing; optional status word via ADBG_TOP_STATUS_EN.
// Select takes effect on the Update-DR edge; outputs are combinational from flops; no backpressure.
module adbg_top_sel
  import adbg_pkg::*;
#(
  parameter int         NB_MODULES       = 4,
  parameter int         MODULE_ID_LENGTH = 2,
  parameter int         DATAREG_LEN      = 64,
  parameter logic [3:0] STATUS_VERSION   = DBG_TOP_STATUS_VERSION
) (
  input  logic           tck_i,
  input  logic           rst_i,
  adbg_top_sel_if.slave  bus
);

  localparam int CW = $clog2(DATAREG_LEN + 1);
  localparam logic [CW-1:0]             CNT_MAX = CW'(DATAREG_LEN);
  localparam logic [CW-1:0]             SEL_MIN = CW'(MODULE_ID_LENGTH + 1);
  localparam logic [MODULE_ID_LENGTH:0] NB_W    = NB_MODULES[MODULE_ID_LENGTH:0];
  localparam logic [NB_MODULES-1:0]     ONE     = 1;

  logic [DATAREG_LEN-1:0]      sr_d, sr_q;
  logic [CW-1:0]               cnt_d, cnt_q;
  logic [MODULE_ID_LENGTH-1:0] id_d, id_q;
  logic                        vld_d, vld_q;
  logic                        err_d, err_q;
  logic [MODULE_ID_LENGTH-1:0] sel_id;
  logic                        status_tdo;

  assign sel_id = sr_q[DATAREG_LEN-2 -: MODULE_ID_LENGTH];

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    id_d  = id_q;
    vld_d = vld_q;
    err_d = err_q;
    if (bus.debug_select_i) begin
      if (bus.shift_dr_i) begin
        sr_d = {bus.tdi_i, sr_q[DATAREG_LEN-1:1]};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      // Capture wins over the increment; update below still sees the pre-edge count.
      if (bus.capture_dr_i) cnt_d = '0;
      if (bus.update_dr_i && sr_q[DATAREG_LEN-1] && !(|bus.top_inhibit_i)) begin
        if (cnt_q < SEL_MIN) begin
          err_d = 1'b1;
        end else if ({1'b0, sel_id} < NB_W) begin
          id_d  = sel_id;
          vld_d = 1'b1;
          err_d = 1'b0;
        end else begin
          vld_d = 1'b0;
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
      id_q  <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      id_q  <= id_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

`ifdef ADBG_TOP_STATUS_EN
  adbg_top_status #(
    .NB_MODULES     (NB_MODULES),
    .STATUS_VERSION (STATUS_VERSION)
  ) u_status (
    .tck_i        (tck_i),
    .rst_i        (rst_i),
    .capture_i    (bus.debug_select_i && bus.capture_dr_i && !vld_q),
    .shift_i      (bus.debug_select_i && bus.shift_dr_i),
    .err_i        (err_q),
    .status_tdo_o (status_tdo)
  );
`else
  assign status_tdo = 1'b0;
`endif

  assign bus.data_register_o = sr_q;
  assign bus.module_select_o = vld_q ? (ONE << id_q) : '0;
  assign bus.tdo_o           = vld_q ? bus.module_tdo_i[id_q] : status_tdo;
  assign bus.select_err_o    = err_q;

endmodule

// File: tb/tb_adbg_top_sel.sv
// Directed bench driving a 4-module and a 3-module selector with identical TAP stimulus.
// Table of select commands plus hand sequences for status, reset and illegal-TAP corners.
module tb_adbg_top_sel;

  logic       tck = 1'b0;
  logic       rst = 1'b1;
  logic       tdi = 1'b0, shift = 1'b0, update = 1'b0, capture = 1'b0, dsel = 1'b1;
  logic [3:0] mtdo = 4'b1111;
  logic [3:0] inh  = 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ADBG_TOP_STATUS_EN
  localparam logic [15:0] EXP_ST4     = 16'h1040;
  localparam logic [15:0] EXP_ST3     = 16'h1030;
  localparam logic [15:0] EXP_ST3_ERR = 16'h1038;
`else
  localparam logic [15:0] EXP_ST4     = 16'h0000;
  localparam logic [15:0] EXP_ST3     = 16'h0000;
  localparam logic [15:0] EXP_ST3_ERR = 16'h0000;
`endif

  always #5 tck = ~tck;

  adbg_top_sel_if #(.NB_MODULES(4), .DATAREG_LEN(64)) if4 ();
  adbg_top_sel_if #(.NB_MODULES(3), .DATAREG_LEN(64)) if3 ();

  assign if4.tdi_i = tdi;          assign if3.tdi_i = tdi;
  assign if4.shift_dr_i = shift;   assign if3.shift_dr_i = shift;
  assign if4.update_dr_i = update; assign if3.update_dr_i = update;
  assign if4.capture_dr_i = capture; assign if3.capture_dr_i = capture;
  assign if4.debug_select_i = dsel;  assign if3.debug_select_i = dsel;
  assign if4.module_tdo_i = mtdo;  assign if3.module_tdo_i = mtdo[2:0];
  assign if4.top_inhibit_i = inh;  assign if3.top_inhibit_i = inh[2:0];

  adbg_top_sel #(.NB_MODULES(4), .MODULE_ID_LENGTH(2), .DATAREG_LEN(64), .STATUS_VERSION(4'h1))
    u_dut4 (.tck_i(tck), .rst_i(rst), .bus(if4.slave));
  adbg_top_sel #(.NB_MODULES(3), .MODULE_ID_LENGTH(2), .DATAREG_LEN(64), .STATUS_VERSION(4'h1))
    u_dut3 (.tck_i(tck), .rst_i(rst), .bus(if3.slave));

  typedef struct {
    logic [2:0] cmd;
    int         nbits;
    logic [3:0] inh;
    logic [3:0] sel4;
    logic       err4;
    logic [2:0] sel3;
    logic       err3;
    logic       tdo4;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // Shifts n bits; the last three carry cmd LSB-first so cmd[2] lands in the MSB.
  task automatic shift_cmd(input logic [2:0] cmd, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = i - (n - 3);
      tdi = (idx >= 0) ? cmd[idx] : 1'b0;
      shift = 1'b1;
      tick();
    end
    shift = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic select_cmd(input logic [2:0] cmd, input int n);
    do_capture();
    shift_cmd(cmd, n);
    do_update();
  endtask

  task automatic read_status(output logic [15:0] s4, output logic [15:0] s3);
    do_capture();
    for (int i = 0; i < 16; i++) begin
      s4[i] = if4.tdo_o;
      s3[i] = if3.tdo_o;
      shift = 1'b1;
      tick();
    end
    shift = 1'b0;
  endtask

  initial begin
    logic [15:0] st4, st3;

    vecs[0] = '{3'b110, 3,  4'b0000, 4'b0100, 1'b0, 3'b100, 1'b0, 1'b1};
    vecs[1] = '{3'b111, 3,  4'b0000, 4'b1000, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[2] = '{3'b101, 3,  4'b0000, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b1};
    vecs[3] = '{3'b100, 3,  4'b0010, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b1};
    vecs[4] = '{3'b011, 3,  4'b0000, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b1};
    vecs[5] = '{3'b111, 2,  4'b0000, 4'b0010, 1'b1, 3'b010, 1'b1, 1'b1};
    vecs[6] = '{3'b100, 70, 4'b0000, 4'b0001, 1'b0, 3'b001, 1'b0, 1'b0};

    tick();
    tick();
    chk("reset_sel4", 64'(if4.module_select_o), 64'h0);
    chk("reset_err4", 64'(if4.select_err_o), 64'h0);
    chk("reset_tdo4", 64'(if4.tdo_o), 64'h0);
    chk("reset_sel3", 64'(if3.module_select_o), 64'h0);
    rst = 1'b0;
    tick();

    read_status(st4, st3);
    chk("status4", 64'(st4), 64'(EXP_ST4));
    chk("status3", 64'(st3), 64'(EXP_ST3));
    chk("status_sel4", 64'(if4.module_select_o), 64'h0);

    mtdo = 4'b0110;
    for (int v = 0; v < 7; v++) begin
      do_capture();
      shift_cmd(vecs[v].cmd, vecs[v].nbits);
      inh = vecs[v].inh;
      do_update();
      inh = 4'b0000;
      chk($sformatf("vec%0d_sel4", v), 64'(if4.module_select_o), 64'(vecs[v].sel4));
      chk($sformatf("vec%0d_err4", v), 64'(if4.select_err_o), 64'(vecs[v].err4));
      chk($sformatf("vec%0d_sel3", v), 64'(if3.module_select_o), 64'(vecs[v].sel3));
      chk($sformatf("vec%0d_err3", v), 64'(if3.select_err_o), 64'(vecs[v].err3));
      chk($sformatf("vec%0d_tdo4", v), 64'(if4.tdo_o), 64'(vecs[v].tdo4));
    end

    // TDO follows the selected module's line combinationally.
    mtdo = 4'b0001;
    #1;
    chk("tdo_follow_hi", 64'(if4.tdo_o), 64'h1);
    mtdo = 4'b1110;
    #1;
    chk("tdo_follow_lo", 64'(if4.tdo_o), 64'h0);

    // Out-of-range select on the 3-module instance, then status shows err.
    select_cmd(3'b111, 3);
    chk("oor_sel3", 64'(if3.module_select_o), 64'h0);
    chk("oor_err3", 64'(if3.select_err_o), 64'h1);
    chk("oor_sel4", 64'(if4.module_select_o), 64'h8);
    read_status(st4, st3);
    chk("status3_err", 64'(st3), 64'(EXP_ST3_ERR));
    select_cmd(3'b101, 3);
    chk("recover_sel3", 64'(if3.module_select_o), 64'h2);
    chk("recover_err3", 64'(if3.select_err_o), 64'h0);

    // DEBUG instruction inactive: everything is ignored.
    dsel = 1'b0;
    select_cmd(3'b110, 3);
    chk("nodsel_sel4", 64'(if4.module_select_o), 64'h2);
    chk("nodsel_err4", 64'(if4.select_err_o), 64'h0);
    chk("nodsel_sel3", 64'(if3.module_select_o), 64'h2);
    dsel = 1'b1;

    // Update together with capture uses the old count, and clears it.
    do_capture();
    shift_cmd(3'b110, 3);
    chk("dreg_msbs", 64'(if4.data_register_o[63:61]), 64'h6);
    update = 1'b1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    update = 1'b0;
    chk("upcap_sel4", 64'(if4.module_select_o), 64'h4);
    chk("upcap_err4", 64'(if4.select_err_o), 64'h0);
    do_update();
    chk("cleared_err4", 64'(if4.select_err_o), 64'h1);
    chk("cleared_sel4", 64'(if4.module_select_o), 64'h4);
    chk("cleared_err3", 64'(if3.select_err_o), 64'h1);

    // Reset in the middle of shifting a select command.
    mtdo = 4'b1111;
    do_capture();
    shift_cmd(3'b101, 2);
    shift = 1'b1;
    tdi = 1'b1;
    #2;
    rst = 1'b1;
    shift = 1'b0;
    tdi = 1'b0;
    #1;
    chk("rstmid_sel4", 64'(if4.module_select_o), 64'h0);
    chk("rstmid_err4", 64'(if4.select_err_o), 64'h0);
    chk("rstmid_tdo4", 64'(if4.tdo_o), 64'h0);
    chk("rstmid_sel3", 64'(if3.module_select_o), 64'h0);
    tick();
    rst = 1'b0;
    do_update();
    chk("post_rst_sel4", 64'(if4.module_select_o), 64'h0);
    chk("post_rst_err4", 64'(if4.select_err_o), 64'h0);
    chk("post_rst_tdo4", 64'(if4.tdo_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
